// File: rtl/dfi_data_sched.sv
// dfi_data_sched: sequences DFI write-data enables and FIFO pops, tags returning read beats
// with AXI id/last, and gates column commands on read credits, write data and queue space.
module dfi_data_sched #(
    parameter int C_ID_WIDTH    = 4,
    parameter int C_LAT_WIDTH   = 5,
    parameter int C_BURST_BEATS = 2,
    parameter int C_TAG_LOG2    = 3,
    parameter int C_RFIFO_LOG2  = 5,
    parameter int C_WLVL_WIDTH  = 6
) (
    input  logic                    core_clk,
    input  logic                    core_arstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [C_ID_WIDTH-1:0]   cmd_id,
    input  logic                    cmd_last,
    input  logic [C_LAT_WIDTH-1:0]  cfg_wrlat,
    input  logic [C_WLVL_WIDTH-1:0] wr_level,
    output logic                    wr_rinc,
    output logic                    dfi_wrdata_en,
    input  logic                    dfi_rddata_valid,
    input  logic                    rd_rinc,
    output logic [C_ID_WIDTH-1:0]   r_id,
    output logic                    r_last,
    output logic [1:0]              r_resp,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [C_ID_WIDTH-1:0]   b_id,
    output logic [1:0]              b_resp,
    output logic                    busy,
    output logic                    err_rd_orphan
);
    localparam int LP_DLY = 2**C_LAT_WIDTH;
    localparam int LP_TQ  = 2**C_TAG_LOG2;
    localparam logic [1:0]                LP_BM1  = 2'(C_BURST_BEATS - 1);
    localparam logic [C_WLVL_WIDTH-1:0]   LP_BW   = C_WLVL_WIDTH'(C_BURST_BEATS);
    localparam logic [C_RFIFO_LOG2:0]     LP_BC   = (C_RFIFO_LOG2+1)'(C_BURST_BEATS);
    localparam logic [C_RFIFO_LOG2:0]     LP_CRED = (C_RFIFO_LOG2+1)'(2**C_RFIFO_LOG2);

    logic [1:0]              r_space;
    logic [C_WLVL_WIDTH-1:0] r_resv;
    logic [LP_DLY-1:0]       r_dly;
    logic [LP_DLY-1:0]       r_dlyl;
    logic [1:0]              r_wcnt;
    logic                    r_wlast;
    logic [C_ID_WIDTH-1:0]   r_bmem [LP_TQ];
    logic [C_TAG_LOG2:0]     r_bwp;
    logic [C_TAG_LOG2:0]     r_bcp;
    logic [C_TAG_LOG2:0]     r_brp;
    logic [C_ID_WIDTH:0]     r_tmem [LP_TQ];
    logic [C_TAG_LOG2:0]     r_twp;
    logic [C_TAG_LOG2:0]     r_trp;
    logic [1:0]              r_beat;
    logic [C_RFIFO_LOG2:0]   r_cred;
    logic                    r_err;

    logic [C_WLVL_WIDTH:0]   w_wavail;
    logic                    w_wok;
    logic [C_TAG_LOG2:0]     w_bocc;
    logic [C_TAG_LOG2:0]     w_tocc;
    logic                    w_bfree;
    logic                    w_tempty;
    logic                    w_tfull;
    logic                    w_rok;
    logic                    w_acc;
    logic                    w_wacc;
    logic                    w_racc;
    logic [C_LAT_WIDTH-1:0]  w_lat;
    logic [C_LAT_WIDTH-1:0]  w_lm1;
    logic                    w_start;
    logic                    w_wfin_last;
    logic [C_ID_WIDTH:0]     w_head;
    logic                    w_blast;

    always_comb begin
        w_wavail    = {1'b0, wr_level} - {1'b0, r_resv};
        w_wok       = !w_wavail[C_WLVL_WIDTH] && (w_wavail >= (C_WLVL_WIDTH+1)'(C_BURST_BEATS));
        w_bocc      = r_bwp - r_brp;
        w_tocc      = r_twp - r_trp;
        w_bfree     = !w_bocc[C_TAG_LOG2];
        w_tempty    = (r_twp == r_trp);
        w_tfull     = w_tocc[C_TAG_LOG2];
        w_rok       = (r_cred >= LP_BC) && !w_tfull;
        cmd_ready   = (r_space == 2'd0) && (cmd_write ? (w_wok && (!cmd_last || w_bfree)) : w_rok);
        w_acc       = cmd_valid && cmd_ready;
        w_wacc      = w_acc && cmd_write;
        w_racc      = w_acc && !cmd_write;
        w_lat       = (cfg_wrlat == '0) ? C_LAT_WIDTH'(1) : cfg_wrlat;
        w_lm1       = w_lat - C_LAT_WIDTH'(1);
        // a set bit reaches position 0 exactly L cycles after the accept that planted it
        w_start     = r_dly[0];
        dfi_wrdata_en = w_start || (r_wcnt != 2'd0);
        wr_rinc     = dfi_wrdata_en;
        w_wfin_last = (C_BURST_BEATS == 1) ? (w_start && r_dlyl[0]) : ((r_wcnt == 2'd1) && r_wlast);
        b_valid     = (r_bcp != r_brp);
        b_id        = b_valid ? r_bmem[r_brp[C_TAG_LOG2-1:0]] : '0;
        b_resp      = 2'b00;
        w_head      = r_tmem[r_trp[C_TAG_LOG2-1:0]];
        w_blast     = (r_beat == LP_BM1);
        r_id        = w_tempty ? '0 : w_head[C_ID_WIDTH:1];
        r_last      = w_tempty ? dfi_rddata_valid : (w_head[0] && w_blast);
        r_resp      = (w_tempty && dfi_rddata_valid) ? 2'b10 : 2'b00;
        busy        = (r_resv != '0) || (r_dly != '0) || !w_tempty || b_valid;
        err_rd_orphan = r_err;
    end

    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            r_space <= '0;
            r_resv  <= '0;
            r_dly   <= '0;
            r_dlyl  <= '0;
            r_wcnt  <= '0;
            r_wlast <= 1'b0;
            r_bwp   <= '0;
            r_bcp   <= '0;
            r_brp   <= '0;
            r_twp   <= '0;
            r_trp   <= '0;
            r_beat  <= '0;
            r_cred  <= LP_CRED;
            r_err   <= 1'b0;
        end else begin
            r_space <= w_acc ? LP_BM1 : ((r_space != 2'd0) ? r_space - 2'd1 : r_space);
            r_resv  <= r_resv + (w_wacc ? LP_BW : '0) - C_WLVL_WIDTH'(dfi_wrdata_en);
            r_dly   <= (r_dly >> 1) | (LP_DLY'(w_wacc) << w_lm1);
            r_dlyl  <= (r_dlyl >> 1) | (LP_DLY'(w_wacc && cmd_last) << w_lm1);
            r_wcnt  <= w_start ? LP_BM1 : ((r_wcnt != 2'd0) ? r_wcnt - 2'd1 : r_wcnt);
            r_wlast <= w_start ? r_dlyl[0] : r_wlast;
            // response slot is reserved at accept, made visible only after the final beat
            if (w_wacc && cmd_last)
                r_bwp <= r_bwp + 1'b1;
            if (w_wfin_last)
                r_bcp <= r_bcp + 1'b1;
            if (b_valid && b_ready)
                r_brp <= r_brp + 1'b1;
            if (w_racc)
                r_twp <= r_twp + 1'b1;
            if (dfi_rddata_valid && !w_tempty) begin
                r_beat <= w_blast ? 2'd0 : r_beat + 2'd1;
                if (w_blast)
                    r_trp <= r_trp + 1'b1;
            end
            if (dfi_rddata_valid && w_tempty)
                r_err <= 1'b1;
            r_cred <= r_cred - (w_racc ? LP_BC : '0) + (C_RFIFO_LOG2+1)'(rd_rinc);
        end
    end

    always_ff @(posedge core_clk) begin
        if (w_wacc && cmd_last)
            r_bmem[r_bwp[C_TAG_LOG2-1:0]] <= cmd_id;
        if (w_racc)
            r_tmem[r_twp[C_TAG_LOG2-1:0]] <= {cmd_id, cmd_last};
    end

    always @(posedge core_clk) begin
        if (core_arstn) begin
            assert (r_cred <= LP_CRED);
            assert (r_resv <= wr_level);
        end
    end
endmodule
